hedios_tx_arbiter: RTL and testbench

- Shares the single Hedios serial TX packet queue between N independent packet sources, e.g. the command controller's responses, slot-change notifications and error reporters.
- Arbitrates valid requests, captures the winner's command/data and issues a one-cycle push pulse to the TX queue.
- Never pushes while the queue reports full.
- Sits between the requesters and the TX serializer FIFO.

---
 rtl/hedios_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_hedios_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hedios_tx_arbiter.sv
// rtl/hedios_tx_arbiter.sv - N-way request arbiter feeding the Hedios serial TX packet queue.
// Registered push path: grant in IDLE, one-cycle PUSH strobe, one-cycle GAP for the queue's full-flag latency.
module hedios_tx_arbiter #(
  parameter int REQ_COUNT = 2,
  parameter bit PRIO_REQ0 = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arb_enable,
  input  logic [REQ_COUNT-1:0]    req_valid,
  input  logic [8*REQ_COUNT-1:0]  req_command,
  input  logic [32*REQ_COUNT-1:0] req_data,
  output logic [REQ_COUNT-1:0]    req_ready,
  input  logic                    tx_full,
  input  logic                    tx_empty,
  output logic [7:0]              tx_command,
  output logic [31:0]             tx_data,
  output logic                    tx_push_packet,
  output logic [3:0]              grant_id,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    push_count
);

  typedef enum logic [1:0] {IDLE, PUSH, GAP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            rr_ptr_q, rr_ptr_d;
  logic [7:0]            tx_command_q, tx_command_d;
  logic [31:0]           tx_data_q, tx_data_d;
  logic                  tx_push_q, tx_push_d;
  logic [REQ_COUNT-1:0]  req_ready_q, req_ready_d;
  logic [3:0]            grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0]  push_count_q, push_count_d;

  logic [15:0] valid_pad;
  logic        win_found;
  logic        win_prio;
  logic [3:0]  win_idx;
  logic [4:0]  scan;
  logic [7:0]  sel_command;
  logic [31:0] sel_data;

  assign valid_pad = 16'(req_valid);

  // Round-robin search starts just after the last RR winner; index 0 is skipped when it owns strict priority.
  always_comb begin
    win_found = 1'b0;
    win_prio  = 1'b0;
    win_idx   = 4'd0;
    scan      = 5'd0;
    if (PRIO_REQ0 && req_valid[0]) begin
      win_found = 1'b1;
      win_prio  = 1'b1;
    end else begin
      for (int k = 1; k <= REQ_COUNT; k++) begin
        scan = {1'b0, rr_ptr_q} + 5'(k);
        if (scan >= 5'(REQ_COUNT)) begin
          scan = scan - 5'(REQ_COUNT);
        end
        if (!win_found && valid_pad[scan[3:0]] && !(PRIO_REQ0 && (scan == 5'd0))) begin
          win_found = 1'b1;
          win_idx   = scan[3:0];
        end
      end
    end
  end

  always_comb begin
    sel_command = 8'd0;
    sel_data    = 32'd0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (win_idx == 4'(i)) begin
        sel_command = req_command[8*i +: 8];
        sel_data    = req_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    tx_command_d = tx_command_q;
    tx_data_d    = tx_data_q;
    tx_push_d    = 1'b0;
    req_ready_d  = '0;
    grant_id_d   = grant_id_q;
    push_count_d = push_count_q;
    case (state_q)
      IDLE: begin
        if (arb_enable && !tx_full && win_found) begin
          state_d      = PUSH;
          tx_command_d = sel_command;
          tx_data_d    = sel_data;
          tx_push_d    = 1'b1;
          grant_id_d   = win_idx;
          for (int i = 0; i < REQ_COUNT; i++) begin
            req_ready_d[i] = (win_idx == 4'(i));
          end
          if (!win_prio) begin
            rr_ptr_d = win_idx;
          end
        end
      end
      PUSH: begin
        push_count_d = push_count_q + CNT_WIDTH'(1);
        state_d      = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 4'(REQ_COUNT - 1);
      tx_command_q <= 8'd0;
      tx_data_q    <= 32'd0;
      tx_push_q    <= 1'b0;
      req_ready_q  <= '0;
      grant_id_q   <= 4'd0;
      push_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tx_command_q <= tx_command_d;
      tx_data_q    <= tx_data_d;
      tx_push_q    <= tx_push_d;
      req_ready_q  <= req_ready_d;
      grant_id_q   <= grant_id_d;
      push_count_q <= push_count_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign tx_command     = tx_command_q;
  assign tx_data        = tx_data_q;
  assign tx_push_packet = tx_push_q;
  assign grant_id       = grant_id_q;
  assign push_count     = push_count_q;
  assign busy           = (state_q != IDLE) || !tx_empty;

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// tb/tb_hedios_tx_arbiter.sv - self-checking bench for hedios_tx_arbiter.
// Two instances (round-robin with 4-bit counter, strict-priority with 16-bit counter) against a grant-level model.
module tb_hedios_tx_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic arb_enable;
  logic tx_full;
  logic tx_empty;

  logic [N-1:0]    req_valid   [2];
  logic [8*N-1:0]  req_command [2];
  logic [32*N-1:0] req_data    [2];

  logic [N-1:0] o_ready [2];
  logic [7:0]   o_cmd   [2];
  logic [31:0]  o_data  [2];
  logic         o_push  [2];
  logic         o_busy  [2];
  logic [3:0]   o_gid   [2];
  logic [3:0]   o_cnt0;
  logic [15:0]  o_cnt1;

  int checks   = 0;
  int failures = 0;

  int         m_wait  [2];
  int         m_ptr   [2];
  int         m_count [2];
  int         m_mask  [2] = '{15, 65535};
  bit         m_prio  [2] = '{1'b0, 1'b1};
  logic       exp_push  [2];
  logic [N-1:0] exp_ready [2];
  logic [7:0] exp_cmd   [2];
  logic [31:0] exp_data [2];
  int         exp_gid   [2];

  always #5 clk = ~clk;

  hedios_tx_arbiter #(.REQ_COUNT(N), .PRIO_REQ0(1'b0), .CNT_WIDTH(4)) dut_rr (
    .clk(clk), .rst_n(rst_n), .arb_enable(arb_enable),
    .req_valid(req_valid[0]), .req_command(req_command[0]), .req_data(req_data[0]),
    .req_ready(o_ready[0]), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_command(o_cmd[0]), .tx_data(o_data[0]), .tx_push_packet(o_push[0]),
    .grant_id(o_gid[0]), .busy(o_busy[0]), .push_count(o_cnt0)
  );

  hedios_tx_arbiter #(.REQ_COUNT(N), .PRIO_REQ0(1'b1), .CNT_WIDTH(16)) dut_pr (
    .clk(clk), .rst_n(rst_n), .arb_enable(arb_enable),
    .req_valid(req_valid[1]), .req_command(req_command[1]), .req_data(req_data[1]),
    .req_ready(o_ready[1]), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_command(o_cmd[1]), .tx_data(o_data[1]), .tx_push_packet(o_push[1]),
    .grant_id(o_gid[1]), .busy(o_busy[1]), .push_count(o_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr, input bit prio);
    if (prio && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (!(prio && i == 0) && v[i]) return i;
    end
    return -1;
  endfunction

  // After a grant the arbiter is unavailable for two more edges; the count bumps on the first of them.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_wait[d] = 0; m_ptr[d] = N - 1; m_count[d] = 0;
        exp_push[d] = 1'b0; exp_ready[d] = '0; exp_cmd[d] = 8'd0; exp_data[d] = 32'd0; exp_gid[d] = 0;
      end else begin
        exp_push[d]  = 1'b0;
        exp_ready[d] = '0;
        if (m_wait[d] == 0) begin
          int w;
          w = (arb_enable && !tx_full) ? pick(req_valid[d], m_ptr[d], m_prio[d]) : -1;
          if (w >= 0) begin
            exp_push[d]     = 1'b1;
            exp_ready[d][w] = 1'b1;
            exp_cmd[d]      = req_command[d][8*w +: 8];
            exp_data[d]     = req_data[d][32*w +: 32];
            exp_gid[d]      = w;
            if (!(m_prio[d] && w == 0)) m_ptr[d] = w;
            m_wait[d] = 2;
          end
        end else begin
          if (m_wait[d] == 2) m_count[d] = (m_count[d] + 1) & m_mask[d];
          m_wait[d]--;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_push", d),  64'(o_push[d]),  64'(exp_push[d]));
      chk($sformatf("d%0d_ready", d), 64'(o_ready[d]), 64'(exp_ready[d]));
      chk($sformatf("d%0d_cmd", d),   64'(o_cmd[d]),   64'(exp_cmd[d]));
      chk($sformatf("d%0d_data", d),  64'(o_data[d]),  64'(exp_data[d]));
      chk($sformatf("d%0d_gid", d),   64'(o_gid[d]),   64'(exp_gid[d]));
      chk($sformatf("d%0d_busy", d),  64'(o_busy[d]),  64'((m_wait[d] != 0) || !tx_empty));
    end
    chk("d0_count", 64'(o_cnt0), 64'(m_count[0]));
    chk("d1_count", 64'(o_cnt1), 64'(m_count[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic new_pkt(input int d, input int i);
    req_command[d][8*i +: 8] = 8'($urandom);
    req_data[d][32*i +: 32]  = $urandom;
  endtask

  // Requesters react to the model's acknowledge, never to the DUT's.
  task automatic stim_update();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ready[d][i]) begin
          if ($urandom_range(1, 0) == 0) req_valid[d][i] = 1'b0;
          else new_pkt(d, i);
        end else if (!req_valid[d][i] && $urandom_range(3, 0) == 0) begin
          req_valid[d][i] = 1'b1;
          new_pkt(d, i);
        end
      end
    end
    tx_full    = ($urandom_range(3, 0) == 0);
    arb_enable = ($urandom_range(9, 0) != 0);
    tx_empty   = $urandom_range(1, 0) == 1;
  endtask

  initial begin
    bit did_rst;
    did_rst    = 1'b0;
    rst_n      = 1'b0;
    arb_enable = 1'b0;
    tx_full    = 1'b0;
    tx_empty   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_command[d] = '0; req_data[d] = '0;
    end
    tick();
    tick();
    chk("rst_count", 64'(o_cnt0), 64'd0);
    chk("rst_ready", 64'(o_ready[1]), 64'd0);
    chk("rst_gid", 64'(o_gid[0]), 64'd0);
    chk("rst_push", 64'(o_push[1]), 64'd0);

    rst_n      = 1'b1;
    arb_enable = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 3'b001; req_command[d][7:0] = 8'h03; req_data[d][31:0] = 32'd0;
    end
    tick();
    chk("single_push", 64'(o_push[0]), 64'd1);
    chk("single_ready", 64'(o_ready[0]), 64'b001);
    chk("single_cmd", 64'(o_cmd[0]), 64'h03);
    chk("single_gid", 64'(o_gid[1]), 64'd0);
    for (int d = 0; d < 2; d++) req_valid[d] = '0;
    tick();
    chk("single_count", 64'(o_cnt0), 64'd1);
    tick();
    tick();

    tx_full = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 3'b010; req_command[d][15:8] = 8'hA5; req_data[d][63:32] = 32'h1234_5678;
    end
    repeat (10) begin
      tick();
      chk("full_no_push", 64'(o_push[0]), 64'd0);
      chk("full_no_ready", 64'(o_ready[1]), 64'd0);
    end
    tx_full = 1'b0;
    tick();
    chk("full_rel_push", 64'(o_push[0]), 64'd1);
    chk("full_rel_ready", 64'(o_ready[0]), 64'b010);
    chk("full_rel_data", 64'(o_data[0]), 64'h1234_5678);
    chk("full_rel_cmd", 64'(o_cmd[1]), 64'hA5);
    for (int d = 0; d < 2; d++) req_valid[d] = '0;
    tick();
    tick();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) req_data[d][32*i +: 32] = 32'h100 + 32'(i);
      req_valid[d] = 3'b111;
    end
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_gid", 64'(o_gid[0]), 64'(g % 3));
      chk("rr_data", 64'(o_data[0]), 64'(32'h100 + 32'(g % 3)));
      chk("prio_gid", 64'(o_gid[1]), 64'd0);
      tick();
      tick();
    end
    req_valid[1] = 3'b110;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("prio_alt_gid", 64'(o_gid[1]), 64'(1 + (g % 2)));
      tick();
      tick();
    end

    arb_enable   = 1'b0;
    req_valid[1] = 3'b111;
    repeat (10) begin
      tick();
      chk("dis_no_push", 64'(o_push[0] | o_push[1]), 64'd0);
    end
    arb_enable = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (!did_rst && cyc >= 1500 && (exp_push[0] || exp_push[1])) begin
        rst_n = 1'b0;
        #1;
        model_step();
        compare_all();
        chk("midrst_push", 64'(o_push[0] | o_push[1]), 64'd0);
        chk("midrst_count", 64'(o_cnt1), 64'd0);
        did_rst = 1'b1;
      end
      stim_update();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
